// File: rtl/ahb_lite_mem_ws_if.sv
// rtl/ahb_lite_mem_ws_if.sv - AHB-Lite bus bundle between a master and the ahb_lite_mem_ws RAM slave
interface ahb_lite_mem_ws_if;
    logic [31:0] HADDR;
    logic [2:0]  HBURST;
    logic        HSEL;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HADDR, HBURST, HSEL, HSIZE, HTRANS, HWDATA, HWRITE,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HBURST, HSEL, HSIZE, HTRANS, HWDATA, HWRITE,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_lite_mem_ws.sv
// rtl/ahb_lite_mem_ws.sv - AHB-Lite on-chip RAM slave with read/write wait states and write-to-read forwarding
// Define AHB_LITE_MEM_WS_ERR_EN to answer illegal or out-of-range transfers with a two-cycle ERROR.
module ahb_lite_mem_ws #(
    parameter int ADDR_WIDTH = 6,
    parameter int MEM_WORDS  = 2**ADDR_WIDTH,
    parameter int READ_WAIT  = 1,
    parameter int WRITE_WAIT = 0
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    ahb_lite_mem_ws_if.slave bus
);
    if (READ_WAIT < 0 || READ_WAIT > 15 || WRITE_WAIT < 0 || WRITE_WAIT > 15 ||
        MEM_WORDS < 1 || MEM_WORDS > 2**ADDR_WIDTH) begin : g_bad_param
        $error("ahb_lite_mem_ws: wait states must be 0..15 and MEM_WORDS within 1..2**ADDR_WIDTH");
    end

    localparam logic [3:0]            RW    = 4'(READ_WAIT);
    localparam logic [3:0]            WW    = 4'(WRITE_WAIT);
    localparam logic [ADDR_WIDTH:0]   LIMIT = (ADDR_WIDTH + 1)'(MEM_WORDS);

`ifdef AHB_LITE_MEM_WS_ERR_EN
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;
`else
    typedef enum logic {S_IDLE, S_DATA} state_t;
`endif

    state_t                state, state_n;
    logic [3:0]            cnt, cnt_n;
    logic [ADDR_WIDTH-1:0] d_idx, a_idx, f_idx;
    logic [3:0]            d_strb, a_strb;
    logic                  d_write, d_inrange, a_inrange, f_inrange;
    logic                  hready, hresp, accept, take, commit, fetch_a, fetch_d;
    logic [31:0]           hrdata, f_word;
    logic [31:0]           mem [2**ADDR_WIDTH];
    logic                  unused_bits;

    function automatic logic [3:0] lane_strobes(input logic [2:0] size, input logic [1:0] off);
        case (size)
            3'd0:    return 4'b0001 << off;
            3'd1:    return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    assign a_idx       = bus.HADDR[ADDR_WIDTH+1:2];
    assign a_inrange   = {1'b0, a_idx} < LIMIT;
    assign a_strb      = lane_strobes(bus.HSIZE, bus.HADDR[1:0]);
    assign unused_bits = ^{bus.HBURST, bus.HADDR};

    always_comb begin
        hready = 1'b1;
        hresp  = 1'b0;
        case (state)
            S_DATA: hready = (cnt == 4'd0);
`ifdef AHB_LITE_MEM_WS_ERR_EN
            S_ERR1: begin
                hready = 1'b0;
                hresp  = 1'b1;
            end
            S_ERR2: hresp = 1'b1;
`endif
            default: ;
        endcase
    end

    assign accept = hready && bus.HSEL && bus.HTRANS[1];

`ifdef AHB_LITE_MEM_WS_ERR_EN
    logic req_err;
    assign req_err = !a_inrange || (bus.HADDR[31:ADDR_WIDTH+2] != '0) || (bus.HSIZE > 3'd2) ||
                     (bus.HSIZE == 3'd1 && bus.HADDR[0]) ||
                     (bus.HSIZE == 3'd2 && bus.HADDR[1:0] != 2'b00);
    assign take    = accept && !req_err;
`else
    assign take    = accept;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            S_DATA: begin
                if (cnt != 4'd0) cnt_n = cnt - 4'd1;
                else             state_n = S_IDLE;
            end
`ifdef AHB_LITE_MEM_WS_ERR_EN
            S_ERR1: state_n = S_ERR2;
            S_ERR2: state_n = S_IDLE;
`endif
            default: ;
        endcase
        if (accept) begin
            state_n = S_DATA;
            cnt_n   = bus.HWRITE ? WW : RW;
`ifdef AHB_LITE_MEM_WS_ERR_EN
            if (req_err) begin
                state_n = S_ERR1;
                cnt_n   = 4'd0;
            end
`endif
        end
    end

    // Read data is fetched one edge ahead of the completing cycle: at accept for zero-wait reads,
    // otherwise on the last wait edge.
    assign commit    = (state == S_DATA) && (cnt == 4'd0) && d_write && d_inrange;
    assign fetch_a   = take && !bus.HWRITE && (RW == 4'd0);
    assign fetch_d   = (state == S_DATA) && (cnt == 4'd1) && !d_write;
    assign f_idx     = fetch_a ? a_idx : d_idx;
    assign f_inrange = fetch_a ? a_inrange : d_inrange;

    always_comb begin
        f_word = mem[f_idx];
        for (int i = 0; i < 4; i++) begin
            if (commit && (d_idx == f_idx) && d_strb[i]) f_word[8*i +: 8] = bus.HWDATA[8*i +: 8];
        end
        if (!f_inrange) f_word = '0;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            d_idx     <= '0;
            d_strb    <= 4'd0;
            d_write   <= 1'b0;
            d_inrange <= 1'b0;
            hrdata    <= 32'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                d_idx     <= a_idx;
                d_strb    <= a_strb;
                d_write   <= bus.HWRITE;
                d_inrange <= a_inrange;
            end
            if (fetch_a || fetch_d) hrdata <= f_word;
        end
    end

    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (d_strb[i]) mem[d_idx][8*i +: 8] <= bus.HWDATA[8*i +: 8];
            end
        end
    end

    assign bus.HRDATA = hrdata;
    assign bus.HREADY = hready;
    assign bus.HRESP  = hresp;
endmodule

// File: tb/tb_ahb_lite_mem_ws.sv
// tb/tb_ahb_lite_mem_ws.sv - directed scoreboard bench for ahb_lite_mem_ws (zero-wait and 3-wait instances)
module tb_ahb_lite_mem_ws;
    logic hclk = 1'b0;
    logic hresetn = 1'b0;
    always #5 hclk = ~hclk;

    logic [31:0] haddr, hwdata;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic        hwrite, sel_a, sel_b;

    ahb_lite_mem_ws_if ifa ();
    ahb_lite_mem_ws_if ifb ();

    assign ifa.HADDR  = haddr;
    assign ifa.HBURST = 3'd0;
    assign ifa.HSEL   = sel_a;
    assign ifa.HSIZE  = hsize;
    assign ifa.HTRANS = htrans;
    assign ifa.HWDATA = hwdata;
    assign ifa.HWRITE = hwrite;
    assign ifb.HADDR  = haddr;
    assign ifb.HBURST = 3'd0;
    assign ifb.HSEL   = sel_b;
    assign ifb.HSIZE  = hsize;
    assign ifb.HTRANS = htrans;
    assign ifb.HWDATA = hwdata;
    assign ifb.HWRITE = hwrite;

    ahb_lite_mem_ws #(.ADDR_WIDTH(6), .MEM_WORDS(48), .READ_WAIT(0), .WRITE_WAIT(0))
        dut_a (.HCLK(hclk), .HRESETn(hresetn), .bus(ifa.slave));
    ahb_lite_mem_ws #(.ADDR_WIDTH(6), .MEM_WORDS(64), .READ_WAIT(3), .WRITE_WAIT(1))
        dut_b (.HCLK(hclk), .HRESETn(hresetn), .bus(ifb.slave));

    typedef struct {
        int          id;
        bit          b;
        bit          w;
        logic [1:0]  tr;
        logic [31:0] a;
        logic [2:0]  sz;
        logic [31:0] d;
        bit          chk;
        logic [31:0] exp;
        int          waits;
        bit          resp;
    } op_t;

    op_t ops[$];
    op_t sbq[$];
    int  n_ops    = 0;
    int  checks   = 0;
    int  failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_op(input bit b, input bit w, input logic [1:0] tr, input logic [31:0] a,
                           input logic [2:0] sz, input logic [31:0] d, input bit chk, input bit resp);
        op_t o;
        o.id    = n_ops;
        o.b     = b;
        o.w     = w;
        o.tr    = tr;
        o.a     = a;
        o.sz    = sz;
        o.d     = d;
        o.chk   = chk;
        o.exp   = d;
        o.resp  = resp;
        o.waits = resp ? 1 : (!tr[1] ? 0 : (b ? (w ? 1 : 3) : 0));
        n_ops++;
        ops.push_back(o);
    endtask

    task automatic wr(input bit b, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d,
                      input bit resp = 1'b0);
        push_op(b, 1'b1, 2'b10, a, sz, d, 1'b0, resp);
    endtask

    task automatic rd(input bit b, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] exp,
                      input bit resp = 1'b0);
        push_op(b, 1'b0, 2'b10, a, sz, exp, !resp, resp);
    endtask

    task automatic idle(input bit b);
        push_op(b, 1'b0, 2'b00, 32'h0, 3'd2, 32'h0, 1'b0, 1'b0);
    endtask

    // Pipelined master: address of the next op overlaps the current data phase on the same slave.
    task automatic run_ops();
        int          i     = 0;
        int          cyc   = 0;
        int          waits = 0;
        bit          dp_v  = 1'b0;
        bit          issue, rdy, rsp;
        logic [31:0] rdat;
        op_t         dp;
        op_t         e;
        dp = '{default: 0};
        while ((i < ops.size() || dp_v) && cyc < 500) begin
            issue = (i < ops.size()) && (!dp_v || dp.b == ops[i].b);
            if (issue) begin
                haddr  = ops[i].a;
                hsize  = ops[i].sz;
                hwrite = ops[i].w;
                htrans = ops[i].tr;
                sel_a  = !ops[i].b;
                sel_b  = ops[i].b;
            end else begin
                sel_a  = 1'b0;
                sel_b  = 1'b0;
                htrans = 2'b00;
            end
            hwdata = (dp_v && dp.w) ? dp.d : 32'h0;
            @(negedge hclk);
            rdy  = dp_v ? (dp.b ? ifb.HREADY : ifa.HREADY) : 1'b1;
            rsp  = dp.b ? ifb.HRESP : ifa.HRESP;
            rdat = dp.b ? ifb.HRDATA : ifa.HRDATA;
            if (dp_v && sbq.size() > 0) begin
                if (!rdy) begin
                    waits++;
                    check($sformatf("op%0d_wait_hresp", sbq[0].id), 32'(rsp), 32'(sbq[0].resp));
                end else begin
                    e = sbq.pop_front();
                    check($sformatf("op%0d_hresp", e.id), 32'(rsp), 32'(e.resp));
                    check($sformatf("op%0d_waits", e.id), 32'(waits), 32'(e.waits));
                    if (e.chk) check($sformatf("op%0d_hrdata", e.id), rdat, e.exp);
                    dp_v = 1'b0;
                end
            end
            if (issue && rdy) begin
                dp = ops[i];
                sbq.push_back(ops[i]);
                i++;
                dp_v  = 1'b1;
                waits = 0;
            end
            @(posedge hclk);
            #1;
            cyc++;
        end
        check("run_ops_in_budget", 32'(cyc < 500), 32'd1);
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        ops.delete();
        sbq.delete();
        sel_a  = 1'b0;
        sel_b  = 1'b0;
        htrans = 2'b00;
    endtask

    initial begin
        haddr  = 32'h0;
        hwdata = 32'h0;
        hsize  = 3'd2;
        htrans = 2'b00;
        hwrite = 1'b0;
        sel_a  = 1'b0;
        sel_b  = 1'b0;
        #12;
        check("rst_a_hready", 32'(ifa.HREADY), 32'd1);
        check("rst_a_hresp", 32'(ifa.HRESP), 32'd0);
        check("rst_a_hrdata", ifa.HRDATA, 32'd0);
        check("rst_b_hready", 32'(ifb.HREADY), 32'd1);
        check("rst_b_hresp", 32'(ifb.HRESP), 32'd0);
        check("rst_b_hrdata", ifb.HRDATA, 32'd0);
        @(negedge hclk);
        hresetn = 1'b1;
        @(posedge hclk);
        #1;

        wr(0, 32'h10, 3'd2, 32'hDEADBEEF);
        idle(0);
        rd(0, 32'h10, 3'd2, 32'hDEADBEEF);
        wr(0, 32'h20, 3'd2, 32'h00000000);
        wr(0, 32'h21, 3'd0, 32'h11111111);
        wr(0, 32'h23, 3'd0, 32'h22222222);
        rd(0, 32'h20, 3'd2, 32'h22001100);
        rd(0, 32'h23, 3'd0, 32'h22001100);
        wr(0, 32'h04, 3'd2, 32'h01234567);
        idle(0);
        wr(0, 32'h04, 3'd2, 32'hA5A5A5A5);
        rd(0, 32'h04, 3'd2, 32'hA5A5A5A5);
        wr(0, 32'h06, 3'd1, 32'hBEEF0000);
        rd(0, 32'h04, 3'd2, 32'hBEEFA5A5);
        wr(0, 32'h00, 3'd2, 32'h55667788);
        idle(0);
`ifdef AHB_LITE_MEM_WS_ERR_EN
        rd(0, 32'hC0, 3'd2, 32'h0, 1'b1);
        wr(0, 32'h01, 3'd1, 32'hFFFFFFFF, 1'b1);
        rd(0, 32'h00, 3'd2, 32'h55667788);
        rd(0, 32'h110, 3'd2, 32'h0, 1'b1);
        rd(0, 32'h00, 3'd3, 32'h0, 1'b1);
        rd(0, 32'h02, 3'd1, 32'h55667788);
`else
        wr(0, 32'hC0, 3'd2, 32'h99999999);
        rd(0, 32'hC0, 3'd2, 32'h00000000);
        wr(0, 32'h01, 3'd1, 32'hFFFFAAAA);
        rd(0, 32'h00, 3'd2, 32'h5566AAAA);
        rd(0, 32'h110, 3'd2, 32'hDEADBEEF);
        rd(0, 32'h03, 3'd3, 32'h5566AAAA);
`endif
        wr(1, 32'h08, 3'd2, 32'h12345678);
        rd(1, 32'h08, 3'd2, 32'h12345678);
        rd(1, 32'h0A, 3'd1, 32'h12345678);
        run_ops();

        // Reset pulse in the middle of a 3-wait read on the second instance
        haddr  = 32'h08;
        hsize  = 3'd2;
        hwrite = 1'b0;
        htrans = 2'b10;
        sel_b  = 1'b1;
        @(posedge hclk);
        #1;
        sel_b  = 1'b0;
        htrans = 2'b00;
        check("mid_read_hready_low", 32'(ifb.HREADY), 32'd0);
        check("mid_read_hrdata_held", ifb.HRDATA, 32'h12345678);
        @(posedge hclk);
        #3;
        hresetn = 1'b0;
        #1;
        check("async_rst_hready", 32'(ifb.HREADY), 32'd1);
        check("async_rst_hresp", 32'(ifb.HRESP), 32'd0);
        check("async_rst_hrdata", ifb.HRDATA, 32'd0);
        @(negedge hclk);
        hresetn = 1'b1;
        @(posedge hclk);
        #1;

        rd(1, 32'h08, 3'd2, 32'h12345678);
        rd(0, 32'h10, 3'd2, 32'hDEADBEEF);
        rd(0, 32'h20, 3'd2, 32'h22001100);
        run_ops();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ahb_lite_mem_ws.md
Name: ahb_lite_mem_ws

Overview:
- Parametrised AHB-Lite on-chip RAM slave for the MIPSfpga+ debug/test fabric.
- Stands in for, or sits beside, the SDRAM controller.
- Supports byte-addressed, byte/halfword/word accesses and programmable read/write wait states.
- Pipelined address/data phases, with write-to-read forwarding so back-to-back transfers are correct at zero wait.

Parameters:
ADDR_WIDTH, 6, word-index width; storage is 2**ADDR_WIDTH 32-bit words
MEM_WORDS, 2**ADDR_WIDTH, implemented words (<= 2**ADDR_WIDTH); sets the range limit
READ_WAIT, 1, wait cycles (HREADY low) inserted in every read data phase, 0..15
WRITE_WAIT, 0, wait cycles inserted in every write data phase, 0..15

Ports:
HCLK  in  1  bus clock, single clock domain
HRESETn  in  1  asynchronous active-low reset
HADDR  in  32  byte address
HBURST  in  3  ignored; bursts handled as individual transfers
HSEL  in  1  slave select
HSIZE  in  3  0=byte, 1=halfword, 2=word
HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ
HWDATA  in  32  write data, data phase
HWRITE  in  1  1=write
HRDATA  out  32  read data, registered
HREADY  out  1  transfer done / address accepted
HRESP  out  1  0=OKAY, 1=ERROR

Behaviour:
- Reset, async on HRESETn low: state IDLE, HREADY=1, HRESP=0, HRDATA=0, wait counter=0, pending data phase cleared. RAM contents are not reset. Reset mid-transfer abandons that transfer; any write not yet committed is dropped.
- Address phase accepted at a rising edge when HREADY=1 && HSEL && HTRANS[1]. Captured: word index HADDR[ADDR_WIDTH+1:2], byte offset HADDR[1:0], HSIZE, HWRITE.
- HTRANS IDLE or BUSY, or HSEL=0: no transfer; the next cycle is a zero-wait OKAY data phase.
- Byte strobes:
  - Byte: lane HADDR[1:0].
  - Halfword: lanes {HADDR[1],0} and {HADDR[1],1}.
  - Word: all four lanes.
  - Little-endian; lane n = bits 8n+7:8n.
- States:
  - IDLE: no data phase pending.
  - DATA: data phase, counting waits.
  - ERR1 / ERR2: only with the optional feature.
- Accepted transfer goes to DATA with counter = READ_WAIT or WRITE_WAIT.
- In DATA:
  - Counter > 0: HREADY=0 and the counter decrements.
  - Counter == 0: HREADY=1 and the transfer completes at that edge.
  - If a new address phase is accepted at the same edge, stay in DATA with the counter reloaded; otherwise go to IDLE.
- Write: HWDATA is sampled at the completing edge, and the strobed lanes are written at that edge. Unstrobed bytes are unchanged.
- Read:
  - HRDATA is loaded with the full addressed word one edge before the completing cycle's HREADY=1. With READ_WAIT=0 that is the address-accept edge.
  - HRDATA returns the whole word regardless of size.
  - HRDATA holds its value between reads.
- Forwarding: if a read's RAM fetch edge coincides with a pending write commit to the same word, HRDATA takes the new write bytes on strobed lanes and old RAM bytes elsewhere.
- Throughput: with READ_WAIT=WRITE_WAIT=0, one transfer per cycle sustained.
- Wait counter is 4 bits; a parameter above 15 is a compile-time error.

Optional Feature:
- Macro: AHB_LITE_MEM_WS_ERR_EN.
- Defined — these transfers get an ERROR response with no RAM access:
  - word index >= MEM_WORDS;
  - HADDR[31:ADDR_WIDTH+2] != 0;
  - HSIZE > 2;
  - misaligned halfword (HADDR[0]=1) or word (HADDR[1:0]!=0).
- ERROR response is two cycles: ERR1 (HREADY=0, HRESP=1), then ERR2 (HREADY=1, HRESP=1), then IDLE. A new address phase presented during ERR2 is accepted normally.
- Not defined: HRESP is tied 0, ERR states are absent, upper address bits are ignored, misaligned accesses use the natural strobes of the aligned-down address, HSIZE>2 is treated as word, and out-of-range writes are dropped and reads return 0.

Test Plan:
- Zero-wait word write 0xDEADBEEF to 0x10, then read 0x10 (READ_WAIT=0) -> HREADY stays 1, HRDATA=0xDEADBEEF in the read data phase.
- Byte writes 0x11 to 0x21 and 0x22 to 0x23 over word 0x00000000 at 0x20, then word read -> 0x22001100.
- Back-to-back write 0xA5A5A5A5 to 0x04 followed in the next cycle by a read of 0x04 at zero wait -> forwarded 0xA5A5A5A5, no stall.
- READ_WAIT=3 word read -> exactly 3 HREADY=0 cycles, data valid on the 4th data-phase cycle.
- Async HRESETn pulse during a 3-wait read -> HREADY=1, HRESP=0, HRDATA=0 immediately; earlier written data is still readable.
- With AHB_LITE_MEM_WS_ERR_EN defined and MEM_WORDS=48, read 0xC0 (word 48) -> HREADY 0/1 with HRESP 1/1 over two cycles; halfword write to 0x01 -> ERROR, RAM unchanged.
